mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Program sequencer and I/O front-end that drives the MC14500B ICU from the other side of its request/acknowledge handshake. It fetches instruction words from a synchronous program ROM and presents opcode and selected input bit to the ICU. It then raises the request, waits for the acknowledge, and acts on the ICU's results:
- output-latch writes;
- `JMP`;
- call via `NOPF`;
- `RTN` via a hardware return stack;
- `NOPO` flag pulse.

## Interface
Parameters:
- `ADDR_W`, 8: program-counter width and operand-field width; ROM depth is 2**ADDR_W.
- `IO_W`, 3: I/O select width; 2**IO_W input pins and 2**IO_W output latches, selected by operand[IO_W-1:0].
- `DEPTH`, 4: return-stack entries, ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_addr`  out  ADDR_W  ROM address.
- `pmem_data`  in  4+ADDR_W  ROM word, valid the cycle after `pmem_addr`. Layout: {opcode[3:0], operand[ADDR_W-1:0]}.
- `in_pins`  in  2**IO_W  external inputs.
- `out_pins`  out  2**IO_W  output latches.
- `icu_rst`  out  1  ICU reset, active-high.
- `icu_req`  out  1  drives ICU `req_prev`.
- `icu_ack`  in  1  from ICU `ack_prev`.
- `icu_instr`  out  4  drives ICU `instruction`.
- `icu_data`  out  1  drives ICU `data_in`.
- `icu_write`, `icu_dout`, `icu_jmp`, `icu_rtn`, `icu_flag_o`, `icu_flag_f`  in  1 each  ICU result outputs.
- `flag_o_pulse`  out  1  one-cycle pulse per executed `NOPO`.
- `err`  out  1  sticky stack overflow/underflow; sequencer halts.

## Operation
- Opcodes use the fixed encoding: 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
- FSM states:
  - FETCH: drive `pmem_addr`=PC → LOAD.
  - LOAD: register `icu_instr`=opcode, operand, `icu_data`=in_pins[operand[IO_W-1:0]] → REQ.
  - REQ: `icu_req`=1 → ACK.
  - ACK: hold `icu_req`; stay while `icu_ack`=0; on 1 → EXEC.
  - EXEC: sample ICU results, `icu_req`=0, update PC/stack/latches → RELEASE.
  - RELEASE: stay while `icu_ack`=1; on 0 → FETCH.
  - HALT: entered on `err`; only exit is reset.
- `icu_instr` and `icu_data` are registered and stable from LOAD through RELEASE, so they are settled one full cycle before the `icu_req` rising edge.
- EXEC actions, evaluated in priority order:
  1. `icu_write`=1: out_pins[sel] ← `icu_dout`; PC+1.
  2. `icu_jmp`: PC ← operand.
  3. `icu_flag_f`: call. If the stack is full, set `err` and go to HALT. Otherwise push PC+1, then PC ← operand.
  4. `icu_rtn`: if the stack is empty, set `err` and go to HALT. Otherwise PC ← pop.
  5. `icu_flag_o`: `flag_o_pulse`=1 for this cycle; PC+1.
  6. Anything else: PC+1.
- After `RTN`, the ICU suppresses the first instruction executed. The return address is therefore a filler slot, conventionally `NOPO`; the sequencer still fetches and handshakes it.
- Instructions skipped by `SKZ` or `RTN` also get a full handshake. The ICU reports all results low for them, so PC+1.
- PC arithmetic is modulo 2**ADDR_W. 0xFF+1 → 0x00 for ADDR_W=8. A pushed return address wraps the same way.
- Reset values:
  - PC=0, `pmem_addr`=0, state FETCH.
  - `icu_req`=0, `icu_instr`=0, `icu_data`=0.
  - `out_pins`=0, stack empty, `err`=0, `flag_o_pulse`=0.
  - `icu_rst`=1.
- `icu_rst` deasserts on the first clock edge after `rst_n` rises. FETCH starts on the edge after that.

## Timing
- Minimum 6 cycles per instruction when `icu_ack` follows `icu_req` combinationally: FETCH, LOAD, REQ, ACK, EXEC, RELEASE.
- Each extra cycle of ack latency, in either phase, adds one cycle.
- ICU results are sampled only in EXEC, at least one cycle after `icu_ack` is seen high.
- `out_pins` changes at the end of EXEC.
- Reset asserted mid-handshake clears everything asynchronously and drops `icu_req` immediately. `icu_rst` resets the ICU in the same event.
- Simultaneous call with full stack: `err` wins; PC unchanged; no push.

## Test plan
- Reset release, ROM {1,sel0}, {B,sel0}, {8,sel2}, with in_pins[0]=1. IEN is preset by a preceding {A,sel0} at 0x00. Required: out_pins[2]=1 after STO, and each instruction takes 6 cycles.
- `JMP` at 0x05 with operand 0x40 → next `pmem_addr`=0x40. PC at 0xFF with a plain opcode → next fetch at 0x00.
- Call at 0x10 to 0x30, `RTN` at 0x30 → fetch at 0x11. The instruction at 0x11 must not change out_pins even if it is a `STO`; execution resumes normally at 0x12.
- DEPTH=4, five nested calls → `err`=1 on the fifth. `pmem_addr` is frozen and `icu_req` stays 0 afterwards. A `RTN` with an empty stack likewise → `err`=1.
- Delayed ack: 3-cycle ack rise and 2-cycle fall → instruction takes 11 cycles; `icu_instr` is stable throughout.
- `rst_n` low while in ACK → `icu_req`=0 and `icu_rst`=1 the same cycle; outputs return to reset values; restart at PC 0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Program sequencer / I/O front-end for the MC14500B ICU: fetches ROM words,
// runs the req/ack handshake and applies the ICU results to PC, stack and latches.
module mc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int IO_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_W-1:0]     pmem_addr,
  input  logic [ADDR_W+3:0]     pmem_data,
  input  logic [(1<<IO_W)-1:0]  in_pins,
  output logic [(1<<IO_W)-1:0]  out_pins,
  output logic                  icu_rst,
  output logic                  icu_req,
  input  logic                  icu_ack,
  output logic [3:0]            icu_instr,
  output logic                  icu_data,
  input  logic                  icu_write,
  input  logic                  icu_dout,
  input  logic                  icu_jmp,
  input  logic                  icu_rtn,
  input  logic                  icu_flag_o,
  input  logic                  icu_flag_f,
  output logic                  flag_o_pulse,
  output logic                  err
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    FETCH, LOAD, REQ, ACK, EXEC, RELEASE, HALT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, operand;
  logic [ADDR_W-1:0] stk [0:(1<<IDX_W)-1];
  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic              req_n, ld, do_write, do_call, do_ret, do_err;
  logic              full, empty;

  assign pmem_addr = pc;
  assign pc_inc    = pc + 1'b1;
  assign full      = (sp == SP_W'(DEPTH));
  assign empty     = (sp == '0);
  assign push_idx  = IDX_W'(sp);
  assign top_idx   = IDX_W'(sp - 1'b1);

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_n        = icu_req;
    ld           = 1'b0;
    do_write     = 1'b0;
    do_call      = 1'b0;
    do_ret       = 1'b0;
    do_err       = 1'b0;
    flag_o_pulse = 1'b0;
    case (state)
      // hold off the first fetch until the ICU has left reset
      FETCH:   if (!icu_rst) state_n = LOAD;
      LOAD:    begin ld = 1'b1; state_n = REQ; end
      REQ:     begin req_n = 1'b1; state_n = ACK; end
      ACK:     if (icu_ack) begin req_n = 1'b0; state_n = EXEC; end
      EXEC: begin
        state_n = RELEASE;
        pc_n    = pc_inc;
        if (icu_write) begin
          do_write = 1'b1;
        end else if (icu_jmp) begin
          pc_n = operand;
        end else if (icu_flag_f) begin
          if (full) begin
            do_err  = 1'b1;
            pc_n    = pc;
            state_n = HALT;
          end else begin
            do_call = 1'b1;
            pc_n    = operand;
          end
        end else if (icu_rtn) begin
          if (empty) begin
            do_err  = 1'b1;
            pc_n    = pc;
            state_n = HALT;
          end else begin
            do_ret = 1'b1;
            pc_n   = stk[top_idx];
          end
        end else if (icu_flag_o) begin
          flag_o_pulse = 1'b1;
        end
      end
      RELEASE: if (!icu_ack) state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= '0;
      operand   <= '0;
      icu_instr <= '0;
      icu_data  <= 1'b0;
      icu_req   <= 1'b0;
      out_pins  <= '0;
      sp        <= '0;
      err       <= 1'b0;
      icu_rst   <= 1'b1;
    end else begin
      icu_rst <= 1'b0;
      state   <= state_n;
      pc      <= pc_n;
      icu_req <= req_n;
      if (ld) begin
        icu_instr <= pmem_data[ADDR_W+3:ADDR_W];
        operand   <= pmem_data[ADDR_W-1:0];
        icu_data  <= in_pins[pmem_data[IO_W-1:0]];
      end
      if (do_write) out_pins[operand[IO_W-1:0]] <= icu_dout;
      if (do_call)     sp <= sp + 1'b1;
      else if (do_ret) sp <= sp - 1'b1;
      if (do_err) err <= 1'b1;
    end
  end

  // stack storage needs no reset: sp alone defines which entries are live
  always_ff @(posedge clk) begin
    if (do_call) stk[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer with a behavioural ICU, a ROM and a scoreboard
// of expected {pc, opcode, out_pins, period} checked at each request rising edge.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pmem_addr;
  logic [11:0] pmem_data;
  logic [7:0]  in_pins;
  logic [7:0]  out_pins;
  logic        icu_rst, icu_req, icu_ack, icu_data;
  logic [3:0]  icu_instr;
  logic        icu_write, icu_dout, icu_jmp, icu_rtn, icu_flag_o, icu_flag_f;
  logic        flag_o_pulse, err;

  always #5 clk = ~clk;

  mc_sequencer #(.ADDR_W(8), .IO_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_addr(pmem_addr), .pmem_data(pmem_data),
    .in_pins(in_pins), .out_pins(out_pins), .icu_rst(icu_rst), .icu_req(icu_req),
    .icu_ack(icu_ack), .icu_instr(icu_instr), .icu_data(icu_data),
    .icu_write(icu_write), .icu_dout(icu_dout), .icu_jmp(icu_jmp), .icu_rtn(icu_rtn),
    .icu_flag_o(icu_flag_o), .icu_flag_f(icu_flag_f),
    .flag_o_pulse(flag_o_pulse), .err(err)
  );

  // synchronous program ROM
  logic [11:0] rom [0:255];
  always @(posedge clk) pmem_data <= rom[pmem_addr];

  // ack model: rises rise_x cycles late, stays high fall_x extra cycles
  int rise_x = 0, fall_x = 0;
  int hi_cnt = 0, lo_cnt = 100;
  always @(posedge clk) begin
    if (icu_req) begin
      hi_cnt <= hi_cnt + 1;
      lo_cnt <= 0;
    end else begin
      hi_cnt <= 0;
      if (lo_cnt < 100) lo_cnt <= lo_cnt + 1;
    end
  end
  assign icu_ack = icu_req ? (hi_cnt >= rise_x) : (lo_cnt <= fall_x);

  // behavioural ICU
  logic rr, ien, oen, skip, pend, d_eff;
  assign d_eff = icu_data & ien;
  always_comb begin
    icu_write = 1'b0; icu_dout = 1'b0; icu_jmp = 1'b0;
    icu_rtn = 1'b0; icu_flag_o = 1'b0; icu_flag_f = 1'b0;
    if (!skip) begin
      case (icu_instr)
        4'h8: begin icu_write = oen; icu_dout = rr;  end
        4'h9: begin icu_write = oen; icu_dout = ~rr; end
        4'hC: icu_jmp    = 1'b1;
        4'hD: icu_rtn    = 1'b1;
        4'h0: icu_flag_o = 1'b1;
        4'hF: icu_flag_f = 1'b1;
        default: ;
      endcase
    end
  end
  always @(posedge clk or posedge icu_rst) begin
    if (icu_rst) begin
      rr <= 1'b0; ien <= 1'b0; oen <= 1'b0; skip <= 1'b0; pend <= 1'b0;
    end else if (icu_req && icu_ack) begin
      pend <= 1'b1;
    end else if (pend && !icu_req) begin
      pend <= 1'b0;
      if (skip) skip <= 1'b0;
      else case (icu_instr)
        4'h1: rr <= d_eff;
        4'h2: rr <= ~d_eff;
        4'h3: rr <= rr & d_eff;
        4'h4: rr <= rr & ~d_eff;
        4'h5: rr <= rr | d_eff;
        4'h6: rr <= rr | ~d_eff;
        4'h7: rr <= ~(rr ^ d_eff);
        4'hA: ien <= icu_data;
        4'hB: oen <= icu_data;
        4'hD: skip <= 1'b1;
        4'hE: if (!rr) skip <= 1'b1;
        default: ;
      endcase
    end
  end

  typedef struct {
    logic [7:0] pc;
    logic [3:0] op;
    logic [7:0] outp;
    int         period;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  int cyc = 0, last_rise = 0, pulses = 0;
  logic req_q = 1'b0;
  logic [3:0] cur_op = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_instr(input logic [7:0] pc, input logic [3:0] op,
                              input logic [7:0] outp, input int period);
    exp_t e;
    e.pc = pc; e.op = op; e.outp = outp; e.period = period;
    q.push_back(e);
  endtask

  // monitor: pop one expectation per request rising edge
  always @(negedge clk) begin
    if (icu_req && !req_q) begin
      if (q.size() == 0) chk("extra_req", icu_req, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        cur_op = e.op;
        chk("pc", pmem_addr, e.pc);
        chk("instr", icu_instr, e.op);
        chk("out_pins", out_pins, e.outp);
        if (e.period != 0) chk("period", cyc - last_rise, e.period);
      end
      last_rise = cyc;
    end else if (icu_req) begin
      chk("instr_stable", icu_instr, cur_op);
    end
    if (flag_o_pulse) pulses++;
    req_q <= icu_req;
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    pulses = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_empty(input int budget);
    int i;
    i = 0;
    while (q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_pins = 8'h01;
    clear_rom();

    // basic I/O, JMP, call/return with suppressed slot, PC wrap
    rom[8'h00] = 12'hA00; rom[8'h01] = 12'h100; rom[8'h02] = 12'hB00;
    rom[8'h03] = 12'h802; rom[8'h04] = 12'h000; rom[8'h05] = 12'hC40;
    rom[8'h40] = 12'hC10; rom[8'h10] = 12'hF30; rom[8'h30] = 12'hD00;
    rom[8'h11] = 12'h805; rom[8'h12] = 12'h806; rom[8'h13] = 12'hCFF;
    rom[8'hFF] = 12'h100;
    repeat (3) @(negedge clk);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_req", icu_req, 0);
    chk("rst_icu_rst", icu_rst, 1);
    chk("rst_instr", icu_instr, 0);
    chk("rst_data", icu_data, 0);
    chk("rst_out", out_pins, 0);
    chk("rst_err", err, 0);
    chk("rst_pulse", flag_o_pulse, 0);
    expect_instr(8'h00, 4'hA, 8'h00, 0);
    expect_instr(8'h01, 4'h1, 8'h00, 6);
    expect_instr(8'h02, 4'hB, 8'h00, 6);
    expect_instr(8'h03, 4'h8, 8'h00, 6);
    expect_instr(8'h04, 4'h0, 8'h04, 6);
    expect_instr(8'h05, 4'hC, 8'h04, 6);
    expect_instr(8'h40, 4'hC, 8'h04, 6);
    expect_instr(8'h10, 4'hF, 8'h04, 6);
    expect_instr(8'h30, 4'hD, 8'h04, 6);
    expect_instr(8'h11, 4'h8, 8'h04, 6);
    expect_instr(8'h12, 4'h8, 8'h04, 6);
    expect_instr(8'h13, 4'hC, 8'h44, 6);
    expect_instr(8'hFF, 4'h1, 8'h44, 6);
    expect_instr(8'h00, 4'hA, 8'h44, 6);
    rst_n = 1'b1;
    #1 chk("icu_rst_held", icu_rst, 1);
    @(negedge clk);
    chk("icu_rst_release", icu_rst, 0);
    chk("addr_after_release", pmem_addr, 0);
    wait_empty(200);
    chk("out_final", out_pins, 8'h44);
    chk("flag_o_count", pulses, 1);

    // five nested calls with DEPTH=4 overflow on the fifth
    enter_reset();
    clear_rom();
    rom[8'h00] = 12'hF20; rom[8'h20] = 12'hF40; rom[8'h40] = 12'hF60;
    rom[8'h60] = 12'hF80; rom[8'h80] = 12'hFA0;
    expect_instr(8'h00, 4'hF, 8'h00, 0);
    expect_instr(8'h20, 4'hF, 8'h00, 6);
    expect_instr(8'h40, 4'hF, 8'h00, 6);
    expect_instr(8'h60, 4'hF, 8'h00, 6);
    expect_instr(8'h80, 4'hF, 8'h00, 6);
    rst_n = 1'b1;
    wait_empty(200);
    chk("ovf_err_before", err, 0);
    repeat (20) @(negedge clk);
    chk("ovf_err", err, 1);
    chk("ovf_addr_frozen", pmem_addr, 8'h80);
    chk("ovf_req_low", icu_req, 0);

    // RTN with an empty stack
    enter_reset();
    chk("err_cleared", err, 0);
    clear_rom();
    rom[8'h00] = 12'hD00;
    expect_instr(8'h00, 4'hD, 8'h00, 0);
    rst_n = 1'b1;
    wait_empty(100);
    repeat (20) @(negedge clk);
    chk("unf_err", err, 1);
    chk("unf_addr_frozen", pmem_addr, 8'h00);
    chk("unf_req_low", icu_req, 0);

    // delayed ack: 3 extra rise cycles, 2 extra fall cycles
    enter_reset();
    clear_rom();
    rise_x = 3; fall_x = 2;
    rom[8'h00] = 12'hA00; rom[8'h01] = 12'h100; rom[8'h02] = 12'hB00;
    expect_instr(8'h00, 4'hA, 8'h00, 0);
    expect_instr(8'h01, 4'h1, 8'h00, 11);
    expect_instr(8'h02, 4'hB, 8'h00, 11);
    rst_n = 1'b1;
    wait_empty(200);

    // reset asserted while waiting in ACK
    enter_reset();
    clear_rom();
    rise_x = 3; fall_x = 0;
    rom[8'h00] = 12'hA00; rom[8'h01] = 12'h100; rom[8'h02] = 12'hB00;
    rom[8'h03] = 12'h802; rom[8'h04] = 12'h100;
    expect_instr(8'h00, 4'hA, 8'h00, 0);
    expect_instr(8'h01, 4'h1, 8'h00, 9);
    expect_instr(8'h02, 4'hB, 8'h00, 9);
    expect_instr(8'h03, 4'h8, 8'h00, 9);
    expect_instr(8'h04, 4'h1, 8'h04, 9);
    rst_n = 1'b1;
    for (int i = 0; i < 200 && !(pmem_addr == 8'h04 && icu_req); i++) @(negedge clk);
    chk("reach_ack", (pmem_addr == 8'h04 && icu_req), 1);
    chk("out_before_rst", out_pins, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", icu_req, 0);
    chk("mid_rst_icu_rst", icu_rst, 1);
    chk("mid_rst_out", out_pins, 0);
    chk("mid_rst_addr", pmem_addr, 0);
    chk("mid_rst_instr", icu_instr, 0);
    chk("mid_rst_q", q.size(), 0);
    repeat (2) @(negedge clk);
    q.delete();
    expect_instr(8'h00, 4'hA, 8'h00, 0);
    expect_instr(8'h01, 4'h1, 8'h00, 9);
    rst_n = 1'b1;
    wait_empty(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
